// File: rtl/board_io_pkg.sv
// rtl/board_io_pkg.sv - shared types for the board I/O conditioning shell
// Purpose: LED display mode encoding and reset sequencer state encoding.
// Ports: none (package).
package board_io_pkg;

    // Encodings match the raw mode_sel switch values.
    typedef enum logic [1:0] {
        MODE_DIRECT    = 2'b00,
        MODE_PWM       = 2'b01,
        MODE_HEARTBEAT = 2'b10,
        MODE_RSTSTAT   = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_HOLD   = 2'd1,
        ST_RUN    = 2'd2
    } rst_state_t;

endpackage

// File: rtl/board_io_debounce.sv
// rtl/board_io_debounce.sv - button synchroniser and debouncer
// Purpose: normalises the raw button to "pressed", passes it through a 2-FF
//          synchroniser and only lets a new level through after it has been
//          stable for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   btn_raw     - raw, unsynchronised button pin
//   pressed     - debounced, polarity-normalised button (1 = pressed)
module board_io_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int ACTIVE_HIGH     = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic pressed
);

    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             pressed_raw;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Normalising before the synchroniser lets every flop reset to "pressed",
    // so the SoC stays in reset until a genuine release is seen.
    assign pressed_raw = (ACTIVE_HIGH != 0) ? btn_raw : ~btn_raw;

    always_comb begin
        sync1_d = pressed_raw;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = cnt_q;
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            deb_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            deb_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pressed = deb_q;

endmodule

// File: rtl/board_io_shell.sv
// rtl/board_io_shell.sv - board pin conditioning between FPGA pins and the SoC
// Purpose: turns the raw reset button into a clean stretched SoC reset and
//          drives the LED bank in direct / PWM / heartbeat / reset-status mode.
//          Optional walking-one LED self-test on every entry to RUN when the
//          macro BOARD_IO_SELFTEST_EN is defined.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low global reset
//   btn_rst     - raw reset button
//   mode_sel    - raw 2-bit display mode switch
//   brightness  - PWM duty (quasi-static)
//   soc_leds    - LED vector from the SoC
//   soc_rst_n   - conditioned active-low SoC reset (registered)
//   led         - board LED pins (registered)
//   rst_active  - high while the reset sequencer is not in RUN (registered)
module board_io_shell #(
    parameter int LED_WIDTH             = 8,
    parameter int BTN_ACTIVE_HIGH       = 1,
    parameter int DEBOUNCE_CYCLES       = 500_000,
    parameter int RST_HOLD_CYCLES       = 16,
    parameter int PWM_BITS              = 8,
    parameter int HEARTBEAT_HALF_CYCLES = 25_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 btn_rst,
    input  logic [1:0]           mode_sel,
    input  logic [PWM_BITS-1:0]  brightness,
    input  logic [LED_WIDTH-1:0] soc_leds,
    output logic                 soc_rst_n,
    output logic [LED_WIDTH-1:0] led,
    output logic                 rst_active
);
    import board_io_pkg::*;

    localparam int              HOLD_W    = $clog2(RST_HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam int              HB_W      = $clog2(HEARTBEAT_HALF_CYCLES + 1);
    localparam logic [HB_W-1:0] HB_LAST   = HB_W'(HEARTBEAT_HALF_CYCLES - 1);

    logic                 btn_pressed;
    logic [1:0]           mode_s1_q, mode_s1_d;
    mode_t                mode_s2_q, mode_s2_d;
    rst_state_t           state_q, state_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic                 soc_rst_n_q, soc_rst_n_d;
    logic                 rst_active_q, rst_active_d;
    logic [PWM_BITS-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic [HB_W-1:0]      hb_cnt_q, hb_cnt_d;
    logic                 hb_q, hb_d;
    logic [LED_WIDTH-1:0] led_q, led_d;
    logic [LED_WIDTH-1:0] led_mode;
    logic                 pwm_on;
    logic                 run_now;

    board_io_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_HIGH     (BTN_ACTIVE_HIGH)
    ) u_btn_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_rst),
        .pressed (btn_pressed)
    );

    // Reset sequencer; outputs are registered from the next state so
    // soc_rst_n falls on the same edge that leaves RUN.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_ASSERT: begin
                if (!btn_pressed) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end
            end
            ST_HOLD: begin
                if (btn_pressed) begin
                    state_d    = ST_ASSERT;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = ST_RUN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (btn_pressed) begin
                    state_d = ST_ASSERT;
                end
            end
            default: begin
                state_d    = ST_ASSERT;
                hold_cnt_d = '0;
            end
        endcase
        soc_rst_n_d  = (state_d == ST_RUN);
        rst_active_d = (state_d != ST_RUN);
    end

    // Free-running PWM and heartbeat timebases plus mode synchroniser.
    always_comb begin
        mode_s1_d = mode_sel;
        mode_s2_d = mode_t'(mode_s1_q);
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        pwm_on    = (pwm_cnt_q < brightness);
        hb_d      = hb_q;
        if (hb_cnt_q == HB_LAST) begin
            hb_cnt_d = '0;
            hb_d     = ~hb_q;
        end else begin
            hb_cnt_d = hb_cnt_q + 1'b1;
        end
    end

`ifdef BOARD_IO_SELFTEST_EN
    localparam int               IDX_W    = (LED_WIDTH > 1) ? $clog2(LED_WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LED_WIDTH - 1);

    logic             st_active_q, st_active_d;
    logic [IDX_W-1:0] st_idx_q, st_idx_d;
    logic [HB_W-1:0]  st_cnt_q, st_cnt_d;

    // Walk starts on the HOLD->RUN edge and is dropped by any exit from RUN.
    always_comb begin
        st_active_d = st_active_q;
        st_idx_d    = st_idx_q;
        st_cnt_d    = st_cnt_q;
        if (state_q == ST_HOLD && state_d == ST_RUN) begin
            st_active_d = 1'b1;
            st_idx_d    = '0;
            st_cnt_d    = '0;
        end else if (state_d != ST_RUN) begin
            st_active_d = 1'b0;
        end else if (st_active_q) begin
            if (st_cnt_q == HB_LAST) begin
                st_cnt_d = '0;
                if (st_idx_q == IDX_LAST) begin
                    st_active_d = 1'b0;
                end else begin
                    st_idx_d = st_idx_q + 1'b1;
                end
            end else begin
                st_cnt_d = st_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_active_q <= 1'b0;
            st_idx_q    <= '0;
            st_cnt_q    <= '0;
        end else begin
            st_active_q <= st_active_d;
            st_idx_q    <= st_idx_d;
            st_cnt_q    <= st_cnt_d;
        end
    end
`endif

    // LED mux. Outside RUN only the reset-status mode lights anything.
    always_comb begin
        run_now = (state_q == ST_RUN);
        case (mode_s2_q)
            MODE_DIRECT:    led_mode = soc_leds;
            MODE_PWM:       led_mode = soc_leds & {LED_WIDTH{pwm_on}};
            MODE_HEARTBEAT: begin
                led_mode    = soc_leds;
                led_mode[0] = hb_q;
            end
            default:        led_mode = {LED_WIDTH{rst_active_q}};
        endcase
        if (mode_s2_q != MODE_RSTSTAT && !run_now) begin
            led_d = '0;
        end else begin
            led_d = led_mode;
        end
`ifdef BOARD_IO_SELFTEST_EN
        if (st_active_q && run_now) begin
            led_d = LED_WIDTH'(1) << st_idx_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_s1_q    <= 2'b00;
            mode_s2_q    <= MODE_DIRECT;
            state_q      <= ST_ASSERT;
            hold_cnt_q   <= '0;
            soc_rst_n_q  <= 1'b0;
            rst_active_q <= 1'b1;
            pwm_cnt_q    <= '0;
            hb_cnt_q     <= '0;
            hb_q         <= 1'b0;
            led_q        <= '0;
        end else begin
            mode_s1_q    <= mode_s1_d;
            mode_s2_q    <= mode_s2_d;
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            soc_rst_n_q  <= soc_rst_n_d;
            rst_active_q <= rst_active_d;
            pwm_cnt_q    <= pwm_cnt_d;
            hb_cnt_q     <= hb_cnt_d;
            hb_q         <= hb_d;
            led_q        <= led_d;
        end
    end

    assign soc_rst_n  = soc_rst_n_q;
    assign rst_active = rst_active_q;
    assign led        = led_q;

endmodule

// File: tb/tb_board_io_shell.sv
// tb/tb_board_io_shell.sv - self-checking bench for board_io_shell
module tb_board_io_shell;

    localparam int LW   = 8;
    localparam int DC   = 4;
    localparam int HOLD = 3;
    localparam int HB   = 5;
    localparam int PB   = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          btn;
    logic [1:0]    mode_sel;
    logic [PB-1:0] brightness;
    logic [LW-1:0] soc_leds;
    logic          soc_rst_n;
    logic [LW-1:0] led;
    logic          rst_active;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    board_io_shell #(
        .LED_WIDTH             (LW),
        .BTN_ACTIVE_HIGH       (1),
        .DEBOUNCE_CYCLES       (DC),
        .RST_HOLD_CYCLES       (HOLD),
        .PWM_BITS              (PB),
        .HEARTBEAT_HALF_CYCLES (HB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_rst    (btn),
        .mode_sel   (mode_sel),
        .brightness (brightness),
        .soc_leds   (soc_leds),
        .soc_rst_n  (soc_rst_n),
        .led        (led),
        .rst_active (rst_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: pins seen two edges late through the synchronisers,
    // debounced level flips after DC consecutive disagreeing samples, PWM and
    // heartbeat phase derived from the edge count since reset.
    int            m_cyc, m_st, m_hold, m_age;
    bit            m_deb, m_s, m_run_old, m_pwm_on, m_hb, m_all_diff;
    bit            m_ph[$];
    bit            m_sh[$];
    logic [1:0]    m_mh[$];
    logic [1:0]    m_md;
    logic [LW-1:0] m_lm;
    logic [LW-1:0] e_led;
    bit            e_soc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc = 0; m_st = 0; m_hold = 0; m_age = 0; m_deb = 1'b1;
            m_ph = '{1'b1, 1'b1};
            m_mh = '{2'd0, 2'd0};
            m_sh.delete();
            e_led = '0; e_soc = 1'b0;
        end else begin
            m_s  = m_ph[1];
            m_md = m_mh[1];
            m_ph.push_front(btn == 1'b1); void'(m_ph.pop_back());
            m_mh.push_front(mode_sel);    void'(m_mh.pop_back());
            m_run_old = (m_st == 2);
            m_pwm_on  = (m_cyc % (1 << PB)) < int'(brightness);
            m_hb      = ((m_cyc / HB) % 2) == 1;
            case (m_md)
                2'd0: m_lm = soc_leds;
                2'd1: m_lm = m_pwm_on ? soc_leds : '0;
                2'd2: m_lm = {soc_leds[LW-1:1], m_hb};
                default: m_lm = m_run_old ? '0 : '1;
            endcase
            if (m_md != 2'd3 && !m_run_old) m_lm = '0;
`ifdef BOARD_IO_SELFTEST_EN
            if (m_run_old && m_age < LW * HB) m_lm = LW'(1) << (m_age / HB);
`endif
            e_led = m_lm;
            case (m_st)
                0: if (!m_deb) begin m_st = 1; m_hold = 0; end
                1: if (m_deb) m_st = 0;
                   else if (m_hold == HOLD - 1) m_st = 2;
                   else m_hold++;
                default: if (m_deb) m_st = 0;
            endcase
            if (m_st == 2 && m_run_old) m_age++;
            else m_age = 0;
            m_sh.push_front(m_s);
            if (m_sh.size() > DC) void'(m_sh.pop_back());
            m_all_diff = (m_sh.size() == DC);
            foreach (m_sh[i]) if (m_sh[i] == m_deb) m_all_diff = 1'b0;
            if (m_all_diff) m_deb = m_s;
            e_soc = (m_st == 2);
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_soc_rst_n", soc_rst_n, e_soc);
            check("cyc_rst_active", rst_active, !e_soc);
            check("cyc_led", led, e_led);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_run(input string tag);
        int k;
        k = 0;
        while (!soc_rst_n && k < 80) begin
            @(negedge clk);
            k++;
        end
        check(tag, soc_rst_n, 1'b1);
`ifdef BOARD_IO_SELFTEST_EN
        tick(LW * HB + 4);
`endif
    endtask

    int   lat, cnt, toggles, btn_left;
    logic prev;

    initial begin
        rst_n = 1'b0; btn = 1'b0; mode_sel = 2'd0; brightness = '0; soc_leds = 8'h5A;
        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_soc_rst_n", soc_rst_n, 1'b0);
        check("rst_led", led, 8'h00);
        check("rst_active", rst_active, 1'b1);

        // Power-on: release of rst_n with the button up.
        rst_n = 1'b1;
        lat = 0;
        while (!soc_rst_n && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("por_latency_8_to_10", (lat >= 8 && lat <= 10), 1'b1);
        check("por_rst_active_low", rst_active, 1'b0);
        wait_run("por_run");

        // Short glitch must not reset; mode 11 shows status.
        mode_sel = 2'd3;
        btn = 1'b1; tick(3); btn = 1'b0; tick(8);
        check("glitch_soc_rst_n", soc_rst_n, 1'b1);
        check("rststat_run_led", led, 8'h00);
        btn = 1'b1; tick(6); btn = 1'b0; tick(3);
        check("press_soc_rst_n", soc_rst_n, 1'b0);
        check("press_rst_active", rst_active, 1'b1);
        check("rststat_reset_led", led, 8'hFF);
        mode_sel = 2'd0;
        wait_run("press_run");

        // Re-press shortly after release, around the hold window.
        btn = 1'b1; tick(6); btn = 1'b0; tick(4);
        btn = 1'b1; tick(6); btn = 1'b0;
        wait_run("repress_run");

        // PWM duty counts.
        mode_sel = 2'd1; soc_leds = 8'hFF; brightness = 4'd4; tick(4);
        cnt = 0;
        repeat (16) begin @(negedge clk); if (led == 8'hFF) cnt++; end
        check("pwm_on_cycles_b4", cnt, 4);
        brightness = 4'd15; tick(2);
        cnt = 0;
        repeat (16) begin @(negedge clk); if (led == 8'hFF) cnt++; end
        check("pwm_on_cycles_b15", cnt, 15);
        brightness = 4'd0; tick(2);
        cnt = 0;
        repeat (16) begin @(negedge clk); if (led != 8'h00) cnt++; end
        check("pwm_on_cycles_b0", cnt, 0);

        // Heartbeat: bit 0 toggles every HB cycles, upper bits pass through.
        mode_sel = 2'd2; soc_leds = 8'hA0; tick(4);
        prev = led[0]; toggles = 0;
        repeat (20) begin
            @(negedge clk);
            if (led[0] != prev) toggles++;
            prev = led[0];
        end
        check("hb_toggles_20", toggles, 4);
        check("hb_upper_bits", led[7:1], 7'h50);

        // Randomised traffic against the model.
        btn_left = 30;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            soc_leds = LW'($urandom);
            if ($urandom_range(0, 15) == 0) mode_sel = 2'($urandom);
            if ($urandom_range(0, 31) == 0) brightness = PB'($urandom);
            btn_left--;
            if (btn_left <= 0) begin
                btn = ~btn;
                btn_left = btn ? $urandom_range(1, 8) : $urandom_range(1, 70);
            end
        end
        btn = 1'b0;
        wait_run("final_run");
        tick(2);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/board_io_shell.md
Name: board_io_shell

Overview:
- Parametrised board-level I/O conditioning stage between raw FPGA board pins and the Grande_Risco_5_SOC.
- Conditions the raw reset button into a clean, stretched SoC reset.
- Drives a configurable-width LED bank from the SoC LED outputs in one of four display modes: direct, PWM-dimmed, heartbeat, reset-status.
- Every board wrapper instantiates it instead of hard-wiring the reset inversion and LED connection.

Parameters:
- LED_WIDTH, 8: number of LED channels.
- BTN_ACTIVE_HIGH, 1: 1 = button pressed is logic 1; 0 = pressed is logic 0.
- DEBOUNCE_CYCLES, 500_000: cycles the synchronised button must stay stable before the debounced value changes (≥2).
- RST_HOLD_CYCLES, 16: cycles soc_rst_n stays low after debounced release (≥1).
- PWM_BITS, 8: width of the brightness input and the PWM counter.
- HEARTBEAT_HALF_CYCLES, 25_000_000: half-period of the heartbeat blink (≥1).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low global reset
- btn_rst  input  1  raw, unsynchronised board reset button
- mode_sel  input  2  raw switch input: 00 direct, 01 PWM, 10 heartbeat, 11 reset-status
- brightness  input  PWM_BITS  PWM duty, quasi-static
- soc_leds  input  LED_WIDTH  LED vector from the SoC
- soc_rst_n  output  1  conditioned active-low reset to the SoC
- led  output  LED_WIDTH  board LED pins
- rst_active  output  1  high while the reset FSM is not in RUN

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). While rst_n=0, all state clears:
  - FSM is in ASSERT; soc_rst_n=0; rst_active=1; led=0.
  - Debounced button reads "pressed"; all counters are 0.
- Synchronisers:
  - btn_rst and mode_sel[1:0] each pass through a 2-FF synchroniser.
  - btn_rst is polarity-normalised via BTN_ACTIVE_HIGH to "pressed".
- Debounce:
  - Counter clears whenever synced value equals debounced value; otherwise it increments.
  - On reaching DEBOUNCE_CYCLES-1, the debounced value takes the synced value and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never propagate.
- Reset FSM, states ASSERT, HOLD, RUN:
  - ASSERT: soc_rst_n=0. Go to HOLD when debounced pressed=0.
  - HOLD: soc_rst_n=0; hold counter increments each cycle. Go to RUN when counter reaches RST_HOLD_CYCLES-1. Debounced press in HOLD returns to ASSERT and clears the counter.
  - RUN: soc_rst_n=1. Debounced press returns to ASSERT; soc_rst_n falls on the next clock edge.
  - soc_rst_n and rst_active are registered outputs. rst_active = (state != RUN).
- Latency: button release to soc_rst_n=1 is 2 (sync) + DEBOUNCE_CYCLES + RST_HOLD_CYCLES cycles, ±1.
- PWM:
  - Free-running PWM_BITS counter, wraps 2^PWM_BITS-1 → 0.
  - pwm_on = (pwm_cnt < brightness).
  - brightness=0 → always off; all-ones → on 2^PWM_BITS-1 of every 2^PWM_BITS cycles.
- Heartbeat: counter toggles hb each HEARTBEAT_HALF_CYCLES cycles. Counter and hb run in all FSM states.
- LED output, registered, one-cycle latency from soc_leds/mode:
  - 00: led = soc_leds.
  - 01: led = soc_leds & {LED_WIDTH{pwm_on}}.
  - 10: led[0] = hb; led[LED_WIDTH-1:1] = soc_leds[LED_WIDTH-1:1].
  - 11: led = {LED_WIDTH{rst_active}}.
- While the FSM is not in RUN, led = 0 in modes 00, 01 and 10. Mode 11 still shows all ones.
- A mode change takes effect 3 cycles after the raw edge (2 sync + 1 register), with no glitch beyond that.

Optional Feature:
- Macro: BOARD_IO_SELFTEST_EN.
- Defined:
  - On every HOLD→RUN transition, a walking-one pattern overrides led regardless of mode: bit 0, then bit 1, …, bit LED_WIDTH-1.
  - Each step lasts HEARTBEAT_HALF_CYCLES cycles. After the last step, normal mode output resumes.
  - A reset press mid-sequence aborts it; the sequence restarts on the next entry to RUN.
  - soc_rst_n is unaffected.
- Undefined: no self-test logic; led follows mode immediately on entry to RUN.

Decomposition:
- Package board_io_pkg holds:
  - the mode enum (MODE_DIRECT, MODE_PWM, MODE_HEARTBEAT, MODE_RSTSTAT);
  - the reset FSM state enum (ST_ASSERT, ST_HOLD, ST_RUN).
- One sub-module, board_io_debounce: synchroniser plus debounce counter, parametrised by DEBOUNCE_CYCLES. Instantiated once for btn_rst.
- mode_sel uses plain 2-FF sync logic inline.

Test Plan (sim params: DEBOUNCE_CYCLES=4, RST_HOLD_CYCLES=3, HEARTBEAT_HALF_CYCLES=5, PWM_BITS=4, LED_WIDTH=8):
- Power-on: rst_n=0 with btn released, then rst_n=1 → soc_rst_n=0, led=0, rst_active=1. soc_rst_n rises 2+4+3 (±1) cycles after rst_n deassertion; rst_active then falls.
- Glitch: in RUN, btn pressed for 3 cycles → soc_rst_n stays 1. Held 6 cycles → soc_rst_n=0 and FSM in ASSERT.
- Re-press in HOLD: press for 6 cycles during HOLD → returns to ASSERT; hold count restarts from 0 after release.
- PWM: mode 01, soc_leds=8'hFF, brightness=4 → led=8'hFF for exactly 4 of every 16 cycles. brightness=0 → led=0 constantly.
- Heartbeat and status: mode 10, soc_leds=8'hA0 → led[0] toggles every 5 cycles and led[7:1] follows soc_leds[7:1]. Mode 11 during reset → led=8'hFF; in RUN → led=8'h00.
- With BOARD_IO_SELFTEST_EN: after HOLD→RUN, led = 01, 02, …, 80, 5 cycles each, then soc_leds. A reset press mid-walk → led=0 and the walk restarts after the next release.
